mem_port_sched: RTL
===================

// Module: mem_port_sched
// PURPOSE
// - Schedules the single DRAM-cache memory-controller port between tag/data reads (AR from index extractor) and fill writes (AW+W pairs from fill FIFO).
// - Sits between those sources and m_ar*/m_aw*/m_w*; batches writes by fill-FIFO watermark to limit bus turnarounds, with a read-starvation cap.
// PARAMETERS
// - ADDR_WIDTH     32   address width
// - DATA_WIDTH     512  write data width
// - ID_WIDTH       4    AXI ID width
// - LVL_WIDTH      7    fill-FIFO occupancy width
// - HI_WM          48   occupancy >= HI_WM enters write drain
// - LO_WM          16   occupancy <= LO_WM leaves write drain; must be < HI_WM
// - RD_STARVE_MAX  32   max drain cycles with a read waiting before forced exit
// PORTS
// - clk             in   1           clock
// - rst             in   1           asynchronous reset, active-high
// - rd_arid_i       in   ID_WIDTH    read request ID
// - rd_araddr_i     in   ADDR_WIDTH  read request address
// - rd_arvalid_i    in   1           read request valid
// - rd_arready_o    out  1           read request ready
// - wr_awid_i       in   ID_WIDTH    fill write ID
// - wr_awaddr_i     in   ADDR_WIDTH  fill write address
// - wr_awvalid_i    in   1           fill write address valid
// - wr_awready_o    out  1           fill write address ready
// - wr_wid_i        in   ID_WIDTH    fill write data ID
// - wr_wdata_i      in   DATA_WIDTH  fill write data
// - wr_wvalid_i     in   1           fill write data valid
// - wr_wready_o     out  1           fill write data ready
// - fill_level_i    in   LVL_WIDTH   fill-FIFO occupancy
// - m_ar{id,addr,valid}_o / m_arready_i  AR to memory ctrl (passthrough of rd_*)
// - m_aw{id,addr,valid}_o / m_awready_i  AW to memory ctrl (passthrough of wr_aw*)
// - m_w{id,data,valid}_o / m_wready_i    W to memory ctrl (passthrough of wr_w*)
// - sched_state_o   out  1           0=READ, 1=DRAIN (debug)
// BEHAVIOUR
// - Reset (rst high): state READ, starve_cnt=0, aw_done=w_done=0; all valid/ready outputs forced 0 combinationally while rst high.
// - Mid-operation reset drops a half-done pair; upstream FIFOs share rst.
// - Zero-latency muxing: m_* payload = source payload.
// - m_arvalid_o  = rd_arvalid_i & rd_gnt;    rd_arready_o = m_arready_i & rd_gnt.
// - m_awvalid_o  = wr_awvalid_i & aw_gnt;    wr_awready_o = m_awready_i & aw_gnt.
// - m_wvalid_o   = wr_wvalid_i & w_gnt;      wr_wready_o  = m_wready_i & w_gnt.
// - Write pair = one AW handshake + one W handshake, any order, same cycle allowed.
//   - aw_done/w_done mark the half already done.
//   - Pair open = aw_done ^ w_done; both clear when the pair completes.
// - rd_gnt = (state==READ).
// - new_wr = (state==DRAIN) | (state==READ & !rd_arvalid_i) (opportunistic fill when reads idle).
// - aw_gnt = !aw_done & (w_done | new_wr);   w_gnt = !w_done & (aw_done | new_wr).
// - An open pair always finishes regardless of state.
// - AXI stability: a valid presented and not accepted is never withdrawn.
//   - An AR/AW/W left unaccepted blocks any state change that would drop its grant.
//   - Opportunistic AW/W raised in READ stays granted until its pair completes, even if rd_arvalid_i rises.
// - READ -> DRAIN when fill_level_i >= HI_WM and no m_arvalid_o is pending unaccepted. starve_cnt <= 0.
// - In DRAIN, starve_cnt +1 per cycle with rd_arvalid_i high; saturates at RD_STARVE_MAX.
// - DRAIN -> READ at a write boundary when fill_level_i <= LO_WM, or starve_cnt == RD_STARVE_MAX.
//   - Write boundary: no pair open after this cycle and no AW/W valid left unaccepted.
// - Simultaneous HI_WM and pending unaccepted AR: AR completes first; drain entry follows the next cycle.
// - fill_level_i == 0 in DRAIN: exit at next boundary (LO_WM rule).
// - State updates take effect the cycle after the condition.
// STRUCTURE
// - dram_cache_pkg: sched_state_e {SCHED_READ, SCHED_DRAIN}; default HI_WM/LO_WM/RD_STARVE_MAX constants.
// - Sub-module wr_pair_track: aw_done/w_done flags, pair_open, boundary detection.
// - Top holds the FSM, starve counter and muxing.
// TESTING
// - Reads only, level 0, m_arready_i=1: 10 back-to-back ARs pass in 10 cycles; state stays READ.
// - Level 48 while AR valid and m_arready_i=0: AR held; after accept, DRAIN next cycle, rd_arready_o=0.
// - DRAIN, AW accepted, m_wready_i low 3 cycles while level drops to 10: state stays DRAIN until W accepted, then READ.
// - DRAIN at level 60, rd_arvalid_i held high: forced READ after 32 waiting cycles, at a pair boundary.
// - READ, no reads, level 5: opportunistic pair issues; rd_arvalid_i rises mid-pair: W still completes, AR granted.
// - Assert rst mid-pair: all valid/ready outputs 0 immediately; after release state READ, flags cleared.

Source files
------------

// File: rtl/dram_cache_pkg.sv
// ----------------------------------------------------------------------------
// dram_cache_pkg : shared scheduler types and watermark defaults.  rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dram_cache_pkg;
  typedef enum logic [0:0] {
    SCHED_READ  = 1'b0,
    SCHED_DRAIN = 1'b1
  } sched_state_e;

  localparam int DEF_HI_WM         = 48;
  localparam int DEF_LO_WM         = 16;
  localparam int DEF_RD_STARVE_MAX = 32;
endpackage

`default_nettype wire

// File: rtl/wr_pair_track.sv
// ----------------------------------------------------------------------------
// wr_pair_track : AW/W half-done flags, stall holds and boundary detect. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wr_pair_track (
  input  logic clk,
  input  logic rst,
  input  logic aw_fire,
  input  logic w_fire,
  input  logic aw_stall,
  input  logic w_stall,
  output logic aw_done,
  output logic w_done,
  output logic aw_hold,
  output logic w_hold,
  output logic boundary
);
  logic aw_side;
  logic w_side;
  logic pair_done;

  assign aw_side   = aw_done | aw_fire;
  assign w_side    = w_done | w_fire;
  assign pair_done = aw_side & w_side;
  // Boundary looks at the pair as it will stand after this cycle.
  assign boundary  = ~(aw_side ^ w_side) & ~aw_stall & ~w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      aw_hold <= 1'b0;
      w_hold  <= 1'b0;
    end else begin
      aw_done <= aw_side & ~pair_done;
      w_done  <= w_side & ~pair_done;
      aw_hold <= aw_stall;
      w_hold  <= w_stall;
    end
  end
endmodule

`default_nettype wire

// File: rtl/mem_port_sched.sv
// ----------------------------------------------------------------------------
// mem_port_sched : read/fill-write port scheduler with watermark drain. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_port_sched
  import dram_cache_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 512,
  parameter int ID_WIDTH      = 4,
  parameter int LVL_WIDTH     = 7,
  parameter int HI_WM         = DEF_HI_WM,
  parameter int LO_WM         = DEF_LO_WM,
  parameter int RD_STARVE_MAX = DEF_RD_STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   rd_arid_i,
  input  logic [ADDR_WIDTH-1:0] rd_araddr_i,
  input  logic                  rd_arvalid_i,
  output logic                  rd_arready_o,
  input  logic [ID_WIDTH-1:0]   wr_awid_i,
  input  logic [ADDR_WIDTH-1:0] wr_awaddr_i,
  input  logic                  wr_awvalid_i,
  output logic                  wr_awready_o,
  input  logic [ID_WIDTH-1:0]   wr_wid_i,
  input  logic [DATA_WIDTH-1:0] wr_wdata_i,
  input  logic                  wr_wvalid_i,
  output logic                  wr_wready_o,
  input  logic [LVL_WIDTH-1:0]  fill_level_i,
  output logic [ID_WIDTH-1:0]   m_arid_o,
  output logic [ADDR_WIDTH-1:0] m_araddr_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  output logic [ID_WIDTH-1:0]   m_awid_o,
  output logic [ADDR_WIDTH-1:0] m_awaddr_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [ID_WIDTH-1:0]   m_wid_o,
  output logic [DATA_WIDTH-1:0] m_wdata_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  output logic                  sched_state_o
);
  localparam int CNT_W = $clog2(RD_STARVE_MAX + 1);

  sched_state_e     state;
  logic [CNT_W-1:0] starve_cnt;
  logic             aw_done, w_done, aw_hold, w_hold, boundary;
  logic             rd_gnt, aw_gnt, w_gnt, new_wr;
  logic             ar_stall, aw_stall, w_stall;

  // Grants are masked by rst so every handshake signal is 0 while reset is high.
  assign rd_gnt = ~rst & (state == SCHED_READ);
  assign new_wr = (state == SCHED_DRAIN) | ~rd_arvalid_i;
  assign aw_gnt = ~rst & ~aw_done & (w_done | new_wr | aw_hold);
  assign w_gnt  = ~rst & ~w_done & (aw_done | new_wr | w_hold);

  assign m_arid_o    = rd_arid_i;
  assign m_araddr_o  = rd_araddr_i;
  assign m_arvalid_o = rd_arvalid_i & rd_gnt;
  assign rd_arready_o = m_arready_i & rd_gnt;

  assign m_awid_o    = wr_awid_i;
  assign m_awaddr_o  = wr_awaddr_i;
  assign m_awvalid_o = wr_awvalid_i & aw_gnt;
  assign wr_awready_o = m_awready_i & aw_gnt;

  assign m_wid_o     = wr_wid_i;
  assign m_wdata_o   = wr_wdata_i;
  assign m_wvalid_o  = wr_wvalid_i & w_gnt;
  assign wr_wready_o = m_wready_i & w_gnt;

  assign ar_stall = m_arvalid_o & ~m_arready_i;
  assign aw_stall = m_awvalid_o & ~m_awready_i;
  assign w_stall  = m_wvalid_o & ~m_wready_i;

  wr_pair_track u_pair (
    .clk      (clk),
    .rst      (rst),
    .aw_fire  (m_awvalid_o & m_awready_i),
    .w_fire   (m_wvalid_o & m_wready_i),
    .aw_stall (aw_stall),
    .w_stall  (w_stall),
    .aw_done  (aw_done),
    .w_done   (w_done),
    .aw_hold  (aw_hold),
    .w_hold   (w_hold),
    .boundary (boundary)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SCHED_READ;
      starve_cnt <= '0;
    end else begin
      case (state)
        SCHED_READ: begin
          if ((fill_level_i >= LVL_WIDTH'(HI_WM)) && !ar_stall) begin
            state      <= SCHED_DRAIN;
            starve_cnt <= '0;
          end
        end
        default: begin
          if (rd_arvalid_i && (starve_cnt != CNT_W'(RD_STARVE_MAX)))
            starve_cnt <= starve_cnt + 1'b1;
          if (boundary && ((fill_level_i <= LVL_WIDTH'(LO_WM)) ||
                           (starve_cnt == CNT_W'(RD_STARVE_MAX))))
            state <= SCHED_READ;
        end
      endcase
    end
  end

  assign sched_state_o = (state == SCHED_DRAIN);
endmodule

`default_nettype wire
